// File: rtl/ex.sv
// MIPS execute stage: combinational ALU/shift/compare/move result, HI/LO ownership,
// single-cycle multiply and a 32-step restoring divider that stalls the pipeline.
module ex (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [2:0]  alusel_i,
  input  logic [31:0] reg1_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        stallreq_o
);

  localparam int DATA_W = 32;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [7:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [7:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [7:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [7:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
  localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
  localparam logic [2:0] EXE_RES_ARITH = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_BUSY, S_DONE} div_state_t;

  div_state_t                state, state_nxt;
  logic [5:0]                cnt;
  logic [DATA_W-1:0]         hi, lo;
  logic [DATA_W-1:0]         rem, quo, dvs;
  logic                      neg_q, neg_r;
  logic                      div_stall, div_commit;

  logic signed [DATA_W-1:0]  reg1_s, reg2_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0]       prod_u;
  logic                      is_div, div_signed, hilo_only;
  logic [DATA_W-1:0]         mag1, mag2;
  logic [DATA_W:0]           shifted, trial;
  logic [DATA_W-1:0]         step_rem, q_fin, r_fin;
  logic [4:0]                sh;
  logic [DATA_W-1:0]         logic_res, shift_res, arith_res, move_res;

  assign reg1_s     = reg1_i;
  assign reg2_s     = reg2_i;
  assign sh         = reg1_i[4:0];
  assign prod_s     = $signed({{DATA_W{reg1_i[DATA_W-1]}}, reg1_i}) *
                      $signed({{DATA_W{reg2_i[DATA_W-1]}}, reg2_i});
  assign prod_u     = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};
  assign div_signed = (aluop_i == EXE_DIV_OP);
  assign is_div     = div_signed || (aluop_i == EXE_DIVU_OP);
  assign hilo_only  = is_div || (aluop_i == EXE_MTHI_OP) || (aluop_i == EXE_MTLO_OP) ||
                      (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
  assign mag1       = (div_signed && reg1_i[DATA_W-1]) ? (~reg1_i + 32'd1) : reg1_i;
  assign mag2       = (div_signed && reg2_i[DATA_W-1]) ? (~reg2_i + 32'd1) : reg2_i;

  // Restoring step: remainder/quotient shift as one register pair, keep the trial if it didn't borrow.
  assign shifted    = {rem, quo[DATA_W-1]};
  assign trial      = shifted - {1'b0, dvs};
  assign step_rem   = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
  assign q_fin      = neg_q ? (~quo + 32'd1) : quo;
  assign r_fin      = neg_r ? (~rem + 32'd1) : rem;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (is_div) state_nxt = (reg2_i == '0) ? S_DIVZERO : S_BUSY;
      S_BUSY:    if (cnt == 6'd31) state_nxt = S_DONE;
      S_DIVZERO: state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    div_stall  = 1'b0;
    div_commit = 1'b0;
    case (state)
      S_IDLE:    div_stall  = is_div;
      S_BUSY:    div_stall  = 1'b1;
      S_DIVZERO: div_stall  = 1'b1;
      S_DONE:    div_commit = 1'b1;
      default:   div_stall  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 cnt <= '0;
    else if (state == S_IDLE) cnt <= '0;
    else if (state == S_BUSY) cnt <= cnt + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && is_div && reg2_i != '0) begin
      rem   <= '0;
      quo   <= mag1;
      dvs   <= mag2;
      neg_q <= div_signed && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
      neg_r <= div_signed && reg1_i[DATA_W-1];
    end else if (state == S_BUSY) begin
      rem   <= step_rem;
      quo   <= {quo[DATA_W-2:0], ~trial[DATA_W]};
    end else if (state == S_DIVZERO) begin
      rem   <= '0;
      quo   <= '0;
    end
  end

  // Divider results and EX-stage HI/LO writers never coincide: one instruction occupies EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (div_commit) begin
      hi <= r_fin;
      lo <= q_fin;
    end else begin
      case (aluop_i)
        EXE_MTHI_OP:  hi <= reg1_i;
        EXE_MTLO_OP:  lo <= reg1_i;
        EXE_MULT_OP:  {hi, lo} <= prod_s;
        EXE_MULTU_OP: {hi, lo} <= prod_u;
        default: ;
      endcase
    end
  end

  always_comb begin
    logic_res = '0;
    shift_res = '0;
    arith_res = '0;
    move_res  = '0;
    case (aluop_i)
      EXE_OR_OP:   logic_res = reg1_i | reg2_i;
      EXE_AND_OP:  logic_res = reg1_i & reg2_i;
      EXE_XOR_OP:  logic_res = reg1_i ^ reg2_i;
      EXE_NOR_OP:  logic_res = ~(reg1_i | reg2_i);
      EXE_SLL_OP:  shift_res = reg2_i << sh;
      EXE_SRL_OP:  shift_res = reg2_i >> sh;
      EXE_SRA_OP:  shift_res = reg2_s >>> sh;
      EXE_ADDU_OP: arith_res = reg1_i + reg2_i;
      EXE_SUBU_OP: arith_res = reg1_i - reg2_i;
      EXE_SLT_OP:  arith_res = {31'b0, reg1_s < reg2_s};
      EXE_SLTU_OP: arith_res = {31'b0, reg1_i < reg2_i};
      EXE_MFHI_OP: move_res  = hi;
      EXE_MFLO_OP: move_res  = lo;
      EXE_NOP_OP:  logic_res = '0;
      default:     logic_res = '0;
    endcase
  end

  always_comb begin
    wd_o       = '0;
    wreg_o     = 1'b0;
    wdata_o    = '0;
    stallreq_o = 1'b0;
    if (!rst) begin
      wd_o       = wd_i;
      wreg_o     = wreg_i && !hilo_only;
      stallreq_o = div_stall;
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        EXE_RES_ARITH: wdata_o = arith_res;
        EXE_RES_MOVE:  wdata_o = move_res;
        default:       wdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for the MIPS execute stage: randomized operations against a
// behavioural model of results, HI/LO contents and divide stall timing.
module tb_ex;

  localparam logic [7:0] OP_NOP   = 8'b0000_0000;
  localparam logic [7:0] OP_AND   = 8'b0010_0100;
  localparam logic [7:0] OP_OR    = 8'b0010_0101;
  localparam logic [7:0] OP_XOR   = 8'b0010_0110;
  localparam logic [7:0] OP_NOR   = 8'b0010_0111;
  localparam logic [7:0] OP_SLL   = 8'b0111_1100;
  localparam logic [7:0] OP_SRL   = 8'b0000_0010;
  localparam logic [7:0] OP_SRA   = 8'b0000_0011;
  localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
  localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
  localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
  localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
  localparam logic [7:0] OP_SLT   = 8'b0010_1010;
  localparam logic [7:0] OP_SLTU  = 8'b0010_1011;
  localparam logic [7:0] OP_ADDU  = 8'b0010_0001;
  localparam logic [7:0] OP_SUBU  = 8'b0010_0011;
  localparam logic [7:0] OP_MULT  = 8'b0001_1000;
  localparam logic [7:0] OP_MULTU = 8'b0001_1001;
  localparam logic [7:0] OP_DIV   = 8'b0001_1010;
  localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

  localparam logic [2:0] SEL_NOP   = 3'b000;
  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_MOVE  = 3'b011;
  localparam logic [2:0] SEL_ARITH = 3'b100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop;
  logic [2:0]  alusel;
  logic [31:0] reg1, reg2;
  logic [4:0]  wd;
  logic        wreg;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;

  ex dut (
    .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
    .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  int          n_pass = 0;
  int          n_total = 0;
  logic        check_en = 1'b0;
  logic [31:0] exp_wdata;
  logic        exp_wreg;
  logic [4:0]  exp_wd;
  logic        exp_stall;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] last_wdata;
  logic        last_wreg;

  logic [7:0] ops [18] = '{OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SLL, OP_SRL, OP_SRA,
                          OP_MFHI, OP_MTHI, OP_MFLO, OP_MTLO, OP_SLT, OP_SLTU,
                          OP_ADDU, OP_SUBU, OP_MULT, OP_MULTU, OP_NOP};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("wdata", wdata_o, exp_wdata);
      chk("wreg", 32'(wreg_o), 32'(exp_wreg));
      chk("wd", 32'(wd_o), 32'(exp_wd));
      chk("stallreq", 32'(stallreq_o), 32'(exp_stall));
    end
  end

  function automatic logic [2:0] class_of(input logic [7:0] op);
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOR:       return SEL_LOGIC;
      OP_SLL, OP_SRL, OP_SRA:              return SEL_SHIFT;
      OP_ADDU, OP_SUBU, OP_SLT, OP_SLTU:   return SEL_ARITH;
      OP_MFHI, OP_MFLO:                    return SEL_MOVE;
      default:                             return SEL_NOP;
    endcase
  endfunction

  function automatic logic [31:0] ref_result(input logic [7:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    int s;
    s = int'(a[4:0]);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      OP_NOR:  return ~(a | b);
      OP_SLL:  return b << s;
      OP_SRL:  return b >> s;
      OP_SRA: begin
        r = b >> s;
        if (b[31]) r = r | ~(32'hFFFF_FFFF >> s);
        return r;
      end
      OP_ADDU: return a + b;
      OP_SUBU: return a - b;
      OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
      OP_MFHI: return m_hi;
      OP_MFLO: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic writes_hilo_only(input logic [7:0] op);
    return op inside {OP_MTHI, OP_MTLO, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  endfunction

  task automatic model_update(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p, sa, sb, q, r;
    logic [63:0] pu;
    case (op)
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      OP_MULT: begin
        p = longint'(int'(a)) * longint'(int'(b));
        {m_hi, m_lo} = p;
      end
      OP_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        {m_hi, m_lo} = pu;
      end
      OP_DIV: begin
        if (b == 0) begin m_hi = 0; m_lo = 0; end
        else begin
          sa = longint'(int'(a)); sb = longint'(int'(b));
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      OP_DIVU: begin
        if (b == 0) begin m_hi = 0; m_lo = 0; end
        else begin m_lo = a / b; m_hi = a % b; end
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'(int'($urandom_range(0, 40)));
      5: return 32'(-int'($urandom_range(1, 40)));
      default: return $urandom;
    endcase
  endfunction

  // Single-cycle instruction: drive after the edge, sample mid-cycle, retire on the next edge.
  task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic w);
    aluop = op; alusel = class_of(op); reg1 = a; reg2 = b; wd = 5'($urandom); wreg = w;
    exp_wdata = ref_result(op, a, b);
    exp_wreg  = w && !writes_hilo_only(op);
    exp_wd    = wd;
    exp_stall = 1'b0;
    @(negedge clk); #1;
    last_wdata = wdata_o;
    last_wreg  = wreg_o;
    @(posedge clk);
    model_update(op, a, b);
    #1;
  endtask

  task automatic do_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int n, stalls;
    n = (b == 0) ? 2 : 33;
    stalls = 0;
    aluop = op; alusel = SEL_NOP; reg1 = a; reg2 = b; wd = 5'($urandom); wreg = 1'b1;
    exp_wdata = 0; exp_wreg = 1'b0; exp_wd = wd;
    for (int k = 0; k <= n; k++) begin
      exp_stall = (k < n);
      @(negedge clk); #1;
      if (stallreq_o) stalls++;
      @(posedge clk); #1;
    end
    model_update(op, a, b);
    chk("div_stall_cycles", 32'(stalls), 32'(n));
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk(name, act, exp);
  endtask

  initial begin
    rst = 1'b1;
    aluop = OP_ADDU; alusel = SEL_ARITH; reg1 = 32'd5; reg2 = 32'd6; wd = 5'd9; wreg = 1'b1;
    exp_wdata = 0; exp_wreg = 0; exp_wd = 0; exp_stall = 0;
    @(posedge clk); #1;
    check_en = 1'b1;
    aluop = OP_DIV; alusel = SEL_NOP;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;

    issue(OP_MFHI, 0, 0, 1'b1); lit("reset_hi", last_wdata, 32'h0);
    issue(OP_MFLO, 0, 0, 1'b1); lit("reset_lo", last_wdata, 32'h0);

    issue(OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 1'b1); lit("or", last_wdata, 32'hF0F0_0F0F);
    issue(OP_SUBU, 32'd0, 32'd1, 1'b1);  lit("subu", last_wdata, 32'hFFFF_FFFF);
    issue(OP_SLT, 32'hFFFF_FFFF, 32'd1, 1'b1);  lit("slt", last_wdata, 32'd1);
    issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 1'b1); lit("sltu", last_wdata, 32'd0);
    issue(OP_SRA, 32'd4, 32'h8000_0000, 1'b1);  lit("sra", last_wdata, 32'hF800_0000);
    issue(OP_SRL, 32'd4, 32'h8000_0000, 1'b1);  lit("srl", last_wdata, 32'h0800_0000);

    issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1); lit("mult_wreg", 32'(last_wreg), 32'd0);
    issue(OP_MFHI, 0, 0, 1'b1);  lit("mult_hi", last_wdata, 32'hFFFF_FFFF);
    lit("mfhi_wreg", 32'(last_wreg), 32'd1);
    issue(OP_MFLO, 0, 0, 1'b1);  lit("mult_lo", last_wdata, 32'hFFFF_FFFE);
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
    issue(OP_MFHI, 0, 0, 1'b1);  lit("multu_hi", last_wdata, 32'h1);
    issue(OP_MFLO, 0, 0, 1'b1);  lit("multu_lo", last_wdata, 32'hFFFF_FFFE);

    do_div(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    issue(OP_MFLO, 0, 0, 1'b1);  lit("div_lo", last_wdata, 32'hFFFF_FFFD);
    issue(OP_MFHI, 0, 0, 1'b1);  lit("div_hi", last_wdata, 32'hFFFF_FFFF);
    do_div(OP_DIVU, 32'd100, 32'd7);
    issue(OP_MFLO, 0, 0, 1'b1);  lit("divu_lo", last_wdata, 32'd14);
    issue(OP_MFHI, 0, 0, 1'b1);  lit("divu_hi", last_wdata, 32'd2);

    issue(OP_MTHI, 32'h1234_5678, 0, 1'b1);
    issue(OP_MTLO, 32'h9ABC_DEF0, 0, 1'b1);
    do_div(OP_DIV, 32'd55, 32'd0);
    issue(OP_MFHI, 0, 0, 1'b1);  lit("div0_hi", last_wdata, 32'h0);
    issue(OP_MFLO, 0, 0, 1'b1);  lit("div0_lo", last_wdata, 32'h0);

    // Abort a division with reset while the counter reads 10.
    issue(OP_MTHI, 32'hDEAD_BEEF, 0, 1'b1);
    issue(OP_MTLO, 32'hCAFE_F00D, 0, 1'b1);
    aluop = OP_DIVU; alusel = SEL_NOP; reg1 = 32'd1000; reg2 = 32'd3; wd = 5'd3; wreg = 1'b1;
    exp_wdata = 0; exp_wreg = 0; exp_wd = wd; exp_stall = 1'b1;
    for (int k = 0; k <= 10; k++) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_wd = 0; exp_stall = 1'b0;
    @(negedge clk); #1;
    lit("abort_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 0; m_lo = 0;
    issue(OP_MFHI, 0, 0, 1'b1);  lit("abort_hi", last_wdata, 32'h0);
    issue(OP_MFLO, 0, 0, 1'b1);  lit("abort_lo", last_wdata, 32'h0);
    issue(OP_ADDU, 32'd3, 32'd4, 1'b1); lit("abort_addu", last_wdata, 32'd7);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] a, b;
      a = rand_val();
      b = rand_val();
      if ($urandom_range(0, 99) < 6) begin
        if ($urandom_range(0, 3) == 0) b = 0;
        do_div(($urandom_range(0, 1) == 1) ? OP_DIV : OP_DIVU, a, b);
      end else begin
        issue(ops[$urandom_range(0, 17)], a, b, 1'($urandom_range(0, 1)));
      end
    end

    check_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
